// File: rtl/regfile_pkg.sv
// Shared register-file writeback types and constants.
// Provides address/data widths, the discarded zero register and wb_req_t.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;
    localparam int ZERO_REG   = 31;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two requesters and the register-file write port.
// master: drives req0/req1 valid/addr/data, sees ready and wr_* results.
// slave : the arbiter, drives ready, wr_en/addr/data, grant_id, conflict_cnt.
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 16
);

    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              grant_id;
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  wr_en, wr_addr, wr_data,
        input  grant_id, conflict_cnt
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output wr_en, wr_addr, wr_data,
        output grant_id, conflict_cnt
    );

endinterface

// File: rtl/mux5x2_1.sv
// 5-bit 2:1 mux built from per-bit selects.
// Ports: i_a (sel=0), i_b (sel=1), i_sel, o_y.
module mux5x2_1 (
    input  logic [4:0] i_a,
    input  logic [4:0] i_b,
    input  logic       i_sel,
    output logic [4:0] o_y
);

    for (genvar g = 0; g < 5; g++) begin : g_bit
        assign o_y[g] = i_sel ? i_b[g] : i_a[g];
    end

endmodule

// File: rtl/mux64x2_1.sv
// 64-bit 2:1 mux built from per-bit selects.
// Ports: i_a (sel=0), i_b (sel=1), i_sel, o_y.
module mux64x2_1 (
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    input  logic        i_sel,
    output logic [63:0] o_y
);

    for (genvar g = 0; g < 64; g++) begin : g_bit
        assign o_y[g] = i_sel ? i_b[g] : i_a[g];
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port (ALU=0, load=1).
// Ports: clk, reset (async, active-high), bus (slave modport: requests in,
// ready/wr_en/wr_addr/wr_data/grant_id/conflict_cnt out).
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wb_arbiter_if.slave bus
);

    wb_req_t           w_req0;
    wb_req_t           w_req1;
    logic              w_grant;
    logic              w_xfer;
    logic              w_conflict;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    logic              r_last_grant;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_grant_id;
    logic [CNT_W-1:0]  r_cnt;

    assign w_req0 = '{
        valid: bus.req0_valid,
        addr:  bus.req0_addr,
        data:  bus.req0_data
    };
    assign w_req1 = '{
        valid: bus.req1_valid,
        addr:  bus.req1_addr,
        data:  bus.req1_data
    };

    assign w_conflict = w_req0.valid & w_req1.valid;
    assign w_xfer     = w_req0.valid | w_req1.valid;

    // On conflict the loser of the previous grant wins.
    always_comb begin
        w_grant = 1'b0;
        unique case (1'b1)
            w_conflict:
                w_grant = ~r_last_grant;
            !w_req0.valid && w_req1.valid:
                w_grant = 1'b1;
            w_req0.valid && !w_req1.valid:
                w_grant = 1'b0;
            default:
                w_grant = 1'b0;
        endcase
    end

    assign bus.req0_ready = w_req0.valid & ~w_grant;
    assign bus.req1_ready = w_req1.valid & w_grant;

    mux5x2_1 u_addr_mux (
        .i_a   (w_req0.addr),
        .i_b   (w_req1.addr),
        .i_sel (w_grant),
        .o_y   (w_sel_addr)
    );

    mux64x2_1 u_data_mux (
        .i_a   (w_req0.data),
        .i_b   (w_req1.data),
        .i_sel (w_grant),
        .o_y   (w_sel_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_grant_id   <= 1'b0;
        end else begin
            // Zero-register writes are accepted but never enabled.
            r_wr_en <= w_xfer &&
                       (w_sel_addr != ADDR_W'(ZERO_REG));
            if (w_xfer) begin
                r_wr_addr    <= w_sel_addr;
                r_wr_data    <= w_sel_data;
                r_grant_id   <= w_grant;
                r_last_grant <= w_grant;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_conflict && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.wr_en        = r_wr_en;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    assign bus.grant_id     = r_grant_id;
    assign bus.conflict_cnt = r_cnt;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: port 0 is the ALU result and port 1 is the load data. Each cycle it grants at most one requester using round-robin. The 5-bit destination address and the 64-bit data pass through 2:1 select muxes driven by the grant, and the result is registered toward the register file. Writes to the zero register (X31) are consumed but never reach the register file.

Parameters:
DATA_W, 64, width of writeback data
ADDR_W, 5, register address width
ZERO_REG, 31, register index whose writes are discarded
CNT_W, 16, width of the saturating conflict counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  ALU writeback request
req0_addr  input  ADDR_W  ALU destination register
req0_data  input  DATA_W  ALU result
req0_ready  output  1  ALU request accepted this cycle (combinational)
req1_valid  input  1  load writeback request
req1_addr  input  ADDR_W  load destination register
req1_data  input  DATA_W  load data
req1_ready  output  1  load request accepted this cycle (combinational)
wr_en  output  1  register-file write enable
wr_addr  output  ADDR_W  register-file write address
wr_data  output  DATA_W  register-file write data
grant_id  output  1  requester that produced the current wr_* values
conflict_cnt  output  CNT_W  number of cycles in which both requesters were valid (saturating)

Behaviour:
- Reset (asynchronous, active-high) applies these values immediately:
  - wr_en=0, wr_addr=0, wr_data=0, grant_id=0, conflict_cnt=0.
  - last_grant=1, so req0 wins the first conflict.
- Grant, combinational in the current cycle:
  - Only req0_valid set → grant 0.
  - Only req1_valid set → grant 1.
  - Both valid → grant = ~last_grant.
  - Neither valid → no grant.
- reqN_ready = reqN_valid & (grant==N). The ready signals never assert without the matching valid and are never both high.
- A transfer occurs when valid&ready. Requesters must hold addr/data stable while valid is high and ready is low.
- Registered output, 1-cycle latency. On the clock edge after a transfer:
  - wr_addr <= selected addr
  - wr_data <= selected data
  - grant_id <= grant
  - last_grant <= grant
  - wr_en <= (selected addr != ZERO_REG)
- No transfer in a cycle → wr_en <= 0. wr_addr, wr_data, grant_id and last_grant hold their values.
- ZERO_REG write: the request is accepted (ready=1) and last_grant updates, but wr_en stays 0. wr_addr and wr_data still update.
- Both requesters targeting the same register: each is serviced in round-robin order, one per cycle. There is no merging and no write-order guarantee between the two ports; the hazard unit enforces ordering upstream.
- Continuous conflict: the grant alternates every cycle, giving 50% throughput to each requester. No requester waits more than 1 cycle once the other has been served.
- conflict_cnt increments on every cycle with req0_valid & req1_valid. It saturates at 2^CNT_W-1 and never wraps.
- Reset asserted mid-operation: any in-flight registered write is dropped (wr_en forced to 0). Requesters must re-present after reset deasserts. No partial write may occur.

Decomposition:
- Shared package regfile_pkg holds:
  - constants REG_ADDR_W=5, REG_DATA_W=64, ZERO_REG=31
  - typedef wb_req_t {valid, addr, data}
- Address select uses the existing mux5x2_1, with select = grant.
- Data select uses a new sub-module mux64x2_1, built the same way (per-bit 2:1 mux generate).
- Arbitration state (last_grant) and the output register stay in regfile_wb_arbiter.

Test Plan:
- Reset then idle: assert reset mid-cycle → all outputs 0 immediately. Deassert, hold no valids for 5 cycles → wr_en stays 0 and conflict_cnt stays 0.
- Single requester: req0 valid, addr=5, data=64'hDEAD_BEEF → req0_ready=1 in the same cycle. Next cycle: wr_en=1, wr_addr=5, wr_data=64'hDEAD_BEEF, grant_id=0.
- Conflict alternation: both valid for 4 cycles (req0 addr=3 data=0x11, req1 addr=7 data=0x22) → grants go 0,1,0,1. wr_addr sequence is 3,7,3,7, each 1 cycle later. conflict_cnt=4.
- Zero-register discard: req1 valid, addr=31, data=0xFF → req1_ready=1. Next cycle: wr_en=0, grant_id=1. A following conflict grants req0.
- Same-destination collision: both valid, addr=9 (data 0xA from req0, 0xB from req1), after reset → wr_data=0xA, then 0xB on consecutive cycles, both with wr_addr=9.
- Reset mid-transfer and saturation:
  - Assert reset the cycle after a transfer → wr_en=0 and no write issued.
  - Separately, with CNT_W=2 and 6 conflict cycles → conflict_cnt holds at 3.
